// File: rtl/axis_row_collector.sv
// ---------------------------------------------------------------------------
// axis_row_collector
//
// Collects pairs of 64-bit AXI-Stream result beats from the accelerator into
// 128-bit PPU output rows (16 x INT8). Completed rows go into a
// first-word-fall-through FIFO that the host-side writer drains. The block
// counts rows against a programmed total, pulses o_done once every row has
// been pushed and drained, and keeps sticky flags for dropped beats and
// (optionally) tlast framing errors.
//
// Optional feature macro: ROW_COLLECTOR_TLAST_CHECK_EN
//   defined   -> s_axis_tlast is checked against row boundaries and
//                o_err_framing reports misplaced or missing tlast
//   undefined -> s_axis_tlast is ignored and o_err_framing is tied to 0
//
// Parameters
//   FIFO_DEPTH_LOG2 : row FIFO holds 2^FIFO_DEPTH_LOG2 rows of 128 bits
//   CNT_W           : width of the row counters
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid : incoming result beats
//   s_axis_tready       : high when a beat can be accepted
//   s_axis_tlast        : end-of-frame marker (checked only with the macro)
//   i_start             : level input, rising edge arms a frame
//   i_row_count         : number of rows in the frame, sampled on start
//   o_row_data          : FIFO head {high beat, low beat}, 0 when empty
//   o_row_valid         : FIFO non-empty
//   i_row_ready         : consumer pops the head while o_row_valid is high
//   o_busy              : frame in progress (any state except IDLE)
//   o_done              : one-cycle completion pulse
//   o_rows_received     : rows pushed in the current frame
//   o_overrun           : sticky, a beat arrived while tready was low
//   o_err_framing       : sticky tlast framing error
// ---------------------------------------------------------------------------
module axis_row_collector #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_row_count,
    output logic [127:0]     o_row_data,
    output logic             o_row_valid,
    input  logic             i_row_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_rows_received,
    output logic             o_overrun,
    output logic             o_err_framing
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic                     r_start_d;
    logic [CNT_W-1:0]         r_target;
    logic [CNT_W-1:0]         r_count;
    logic [63:0]              r_low;
    logic                     r_done;
    logic                     r_overrun;

    logic [127:0]             r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0] r_occ;
    logic                     r_full;

    logic                     w_start_edge;
    logic                     w_tready;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_empty;
    logic                     w_last_row;
    logic [CNT_W-1:0]         w_count_next;
    logic [FIFO_DEPTH_LOG2:0] w_occ_next;

`ifdef ROW_COLLECTOR_TLAST_CHECK_EN
    logic                     r_err_framing;
`else
    logic                     w_unused_tlast;
    assign w_unused_tlast = s_axis_tlast;
`endif

    assign w_start_edge = i_start & ~r_start_d;
    assign w_empty      = (r_occ == '0);
    assign w_pop        = i_row_ready & ~w_empty;
    assign w_push       = (r_state == S_HIGH) & s_axis_tvalid & w_tready;
    assign w_count_next = r_count + CNT_W'(1);
    assign w_last_row   = (w_count_next == r_target);

    // Ready depends only on the state and the registered full flag, so a pop
    // in the same cycle does not re-open the HIGH slot until the next cycle.
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            S_LOW:   w_tready = 1'b1;
            S_HIGH:  w_tready = ~r_full;
            default: w_tready = 1'b0;
        endcase
    end

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + 1'b1;
        end else if (!w_push && w_pop) begin
            w_occ_next = r_occ - 1'b1;
        end
    end

    // Row storage. The data array needs no reset because the head is masked
    // to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_axis_tdata, r_low};
        end
    end

    // FIFO pointers, occupancy and full flag. Occupancy can only reach DEPTH
    // (a power of two) when full, so its top bit is the full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ  <= w_occ_next;
            r_full <= w_occ_next[FIFO_DEPTH_LOG2];
        end
    end

    // Frame control FSM. The done pulse is raised on the way out of DRAIN so
    // it lines up with the last pop; a zero-row frame has no DRAIN, so DONE
    // raises the pulse itself. DONE toggles r_done, which covers both paths
    // with a single one-cycle pulse. The overrun set comes after the case so
    // it wins over the clear done by a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_start_d     <= 1'b0;
            r_target      <= '0;
            r_count       <= '0;
            r_low         <= '0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef ROW_COLLECTOR_TLAST_CHECK_EN
            r_err_framing <= 1'b0;
`endif
        end else begin
            r_start_d <= i_start;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_target      <= i_row_count;
                        r_count       <= '0;
                        r_overrun     <= 1'b0;
`ifdef ROW_COLLECTOR_TLAST_CHECK_EN
                        r_err_framing <= 1'b0;
`endif
                        r_state       <= (i_row_count == '0) ? S_DONE : S_LOW;
                    end
                end
                S_LOW: begin
                    if (s_axis_tvalid) begin
                        r_low   <= s_axis_tdata;
                        r_state <= S_HIGH;
`ifdef ROW_COLLECTOR_TLAST_CHECK_EN
                        if (s_axis_tlast) begin
                            r_err_framing <= 1'b1;
                        end
`endif
                    end
                end
                S_HIGH: begin
                    if (w_push) begin
                        r_count <= w_count_next;
                        r_state <= w_last_row ? S_DRAIN : S_LOW;
`ifdef ROW_COLLECTOR_TLAST_CHECK_EN
                        if (s_axis_tlast != w_last_row) begin
                            r_err_framing <= 1'b1;
                        end
`endif
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= ~r_done;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (s_axis_tvalid && !w_tready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign s_axis_tready   = w_tready;
    assign o_row_valid     = ~w_empty;
    assign o_row_data      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = r_done;
    assign o_rows_received = r_count;
    assign o_overrun       = r_overrun;
`ifdef ROW_COLLECTOR_TLAST_CHECK_EN
    assign o_err_framing   = r_err_framing;
`else
    assign o_err_framing   = 1'b0;
`endif

endmodule

// File: tb/tb_axis_row_collector.sv
// ---------------------------------------------------------------------------
// tb_axis_row_collector
//
// Self-checking bench for axis_row_collector: a cycle table for a basic
// two-row frame, then directed sequences for FIFO fill/overrun, zero-row
// frames, mid-frame reset, ignored restart and tlast framing.
// ---------------------------------------------------------------------------
module tb_axis_row_collector;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [63:0]      sAxisTdata;
    logic             sAxisTvalid;
    logic             sAxisTready;
    logic             sAxisTlast;
    logic             iStart;
    logic [CNT_W-1:0] iRowCount;
    logic [127:0]     oRowData;
    logic             oRowValid;
    logic             iRowReady;
    logic             oBusy;
    logic             oDone;
    logic [CNT_W-1:0] oRowsReceived;
    logic             oOverrun;
    logic             oErrFraming;

    int compared   = 0;
    int mismatched = 0;

    axis_row_collector #(
        .FIFO_DEPTH_LOG2(4),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (sAxisTdata),
        .s_axis_tvalid  (sAxisTvalid),
        .s_axis_tready  (sAxisTready),
        .s_axis_tlast   (sAxisTlast),
        .i_start        (iStart),
        .i_row_count    (iRowCount),
        .o_row_data     (oRowData),
        .o_row_valid    (oRowValid),
        .i_row_ready    (iRowReady),
        .o_busy         (oBusy),
        .o_done         (oDone),
        .o_rows_received(oRowsReceived),
        .o_overrun      (oOverrun),
        .o_err_framing  (oErrFraming)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic [15:0]  cnt;
        logic         valid;
        logic [63:0]  data;
        logic         ready;
        logic         eTready;
        logic         eValid;
        logic [127:0] eRow;
        logic [15:0]  eRows;
        logic         eBusy;
        logic         eDone;
        logic         eOverrun;
    } vec_t;

    vec_t vecs[8];

`ifdef ROW_COLLECTOR_TLAST_CHECK_EN
    localparam logic EXP_FRAMING = 1'b1;
`else
    localparam logic EXP_FRAMING = 1'b0;
`endif

    // Distinct beat pattern: every byte holds k+1.
    function automatic logic [63:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k + 1);
        return {8{b}};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [15:0] cnt, input logic valid,
                                 input logic [63:0] data, input logic last, input logic ready);
        iStart      = start;
        iRowCount   = cnt;
        sAxisTvalid = valid;
        sAxisTdata  = data;
        sAxisTlast  = last;
        iRowReady   = ready;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] bA, bB, bC, bD;
        bA = 64'h1111111111111111;
        bB = 64'h2222222222222222;
        bC = 64'h3333333333333333;
        bD = 64'h4444444444444444;

        vecs[0] = '{1'b1, 16'd2, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 128'h0,   16'd0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'd2, 1'b1, bA,    1'b1, 1'b1, 1'b0, 128'h0,   16'd0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'd2, 1'b1, bB,    1'b1, 1'b1, 1'b1, {bB, bA}, 16'd1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'd2, 1'b1, bC,    1'b1, 1'b1, 1'b0, 128'h0,   16'd1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'd2, 1'b1, bD,    1'b1, 1'b0, 1'b1, {bD, bC}, 16'd2, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'd2, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 128'h0,   16'd2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'd2, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 128'h0,   16'd2, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'd2, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 128'h0,   16'd2, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'd0, 1'b0, 64'h0, 1'b0, 1'b0);
        step();
        step();
        checkBit("rst tready", sAxisTready, 1'b0);
        checkBit("rst valid", oRowValid, 1'b0);
        checkBit("rst busy", oBusy, 1'b0);
        checkBit("rst done", oDone, 1'b0);
        checkBit("rst overrun", oOverrun, 1'b0);
        checkBit("rst framing", oErrFraming, 1'b0);
        checkOutput("rst row", oRowData, 128'h0);
        checkCount("rst rows", oRowsReceived, 16'd0);
        rst_n = 1'b1;
        step();

        // Two-row frame, cycle by cycle
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].start, vecs[i].cnt, vecs[i].valid, vecs[i].data, 1'b0, vecs[i].ready);
            step();
            checkBit($sformatf("t1[%0d] tready", i), sAxisTready, vecs[i].eTready);
            checkBit($sformatf("t1[%0d] valid", i), oRowValid, vecs[i].eValid);
            checkOutput($sformatf("t1[%0d] row", i), oRowData, vecs[i].eRow);
            checkCount($sformatf("t1[%0d] rows", i), oRowsReceived, vecs[i].eRows);
            checkBit($sformatf("t1[%0d] busy", i), oBusy, vecs[i].eBusy);
            checkBit($sformatf("t1[%0d] done", i), oDone, vecs[i].eDone);
            checkBit($sformatf("t1[%0d] overrun", i), oOverrun, vecs[i].eOverrun);
        end

        // FIFO fill with consumer stalled, overrun, then drain in order
        applyStimulus(1'b1, 16'd17, 1'b0, 64'h0, 1'b0, 1'b0);
        step();
        checkBit("t2 start tready", sAxisTready, 1'b1);
        for (int k = 0; k <= 32; k++) begin
            applyStimulus(1'b0, 16'd17, 1'b1, pat(k), 1'b0, 1'b0);
            step();
        end
        checkBit("t2 full tready", sAxisTready, 1'b0);
        checkCount("t2 full rows", oRowsReceived, 16'd16);
        checkBit("t2 full overrun", oOverrun, 1'b0);
        applyStimulus(1'b0, 16'd17, 1'b1, pat(33), 1'b0, 1'b0);
        step();
        checkBit("t2 overrun set", oOverrun, 1'b1);
        checkCount("t2 rows after drop", oRowsReceived, 16'd16);
        applyStimulus(1'b0, 16'd17, 1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkBit($sformatf("t2 pop%0d valid", i), oRowValid, 1'b1);
            checkOutput($sformatf("t2 pop%0d row", i), oRowData, {pat(2 * i + 1), pat(2 * i)});
            step();
            if (i == 0) begin
                checkBit("t2 tready reassert", sAxisTready, 1'b1);
            end
        end
        checkBit("t2 empty valid", oRowValid, 1'b0);
        applyStimulus(1'b0, 16'd17, 1'b1, pat(34), 1'b0, 1'b1);
        step();
        checkCount("t2 final rows", oRowsReceived, 16'd17);
        checkOutput("t2 row16", oRowData, {pat(34), pat(32)});
        checkBit("t2 drain tready", sAxisTready, 1'b0);
        applyStimulus(1'b0, 16'd17, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        step();
        checkBit("t2 done", oDone, 1'b1);
        checkBit("t2 overrun sticky", oOverrun, 1'b1);
        step();
        checkBit("t2 done low", oDone, 1'b0);
        checkBit("t2 idle busy", oBusy, 1'b0);

        // Zero-row frame
        applyStimulus(1'b1, 16'd0, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        checkBit("t3 tready", sAxisTready, 1'b0);
        checkBit("t3 busy", oBusy, 1'b1);
        checkBit("t3 done early", oDone, 1'b0);
        checkBit("t3 overrun cleared", oOverrun, 1'b0);
        step();
        checkBit("t3 done", oDone, 1'b1);
        checkBit("t3 tready2", sAxisTready, 1'b0);
        step();
        checkBit("t3 done low", oDone, 1'b0);

        // Reset in the middle of a frame
        applyStimulus(1'b0, 16'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 16'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 16'd1, 1'b1, pat(50), 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 16'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkBit("t4 rst tready", sAxisTready, 1'b0);
        checkBit("t4 rst busy", oBusy, 1'b0);
        checkBit("t4 rst valid", oRowValid, 1'b0);
        checkCount("t4 rst rows", oRowsReceived, 16'd0);
        #3;
        rst_n = 1'b1;
        step();
        applyStimulus(1'b1, 16'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        checkBit("t4 restart tready", sAxisTready, 1'b1);
        applyStimulus(1'b1, 16'd1, 1'b1, pat(60), 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 16'd1, 1'b1, pat(61), 1'b0, 1'b1);
        step();
        checkOutput("t4 row", oRowData, {pat(61), pat(60)});
        checkCount("t4 rows", oRowsReceived, 16'd1);
        applyStimulus(1'b1, 16'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        step();
        checkBit("t4 done", oDone, 1'b1);
        step();

        // Start edge while busy is ignored
        applyStimulus(1'b0, 16'd2, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 16'd2, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 16'd2, 1'b1, pat(70), 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 16'd2, 1'b1, pat(71), 1'b0, 1'b1);
        step();
        checkCount("t5 rows1", oRowsReceived, 16'd1);
        applyStimulus(1'b0, 16'd5, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 16'd5, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        checkCount("t5 rows kept", oRowsReceived, 16'd1);
        checkBit("t5 still low", sAxisTready, 1'b1);
        applyStimulus(1'b1, 16'd5, 1'b1, pat(72), 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 16'd5, 1'b1, pat(73), 1'b0, 1'b1);
        step();
        checkCount("t5 rows2", oRowsReceived, 16'd2);
        checkOutput("t5 row1", oRowData, {pat(73), pat(72)});
        checkBit("t5 drain tready", sAxisTready, 1'b0);
        applyStimulus(1'b1, 16'd5, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        step();
        checkBit("t5 done", oDone, 1'b1);
        step();
        checkBit("t5 idle", oBusy, 1'b0);

        // tlast on the first (low) beat of a one-row frame
        applyStimulus(1'b0, 16'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 16'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        checkBit("t6 framing cleared", oErrFraming, 1'b0);
        applyStimulus(1'b1, 16'd1, 1'b1, pat(80), 1'b1, 1'b1);
        step();
        checkBit("t6 framing", oErrFraming, EXP_FRAMING);
        applyStimulus(1'b1, 16'd1, 1'b1, pat(81), 1'b1, 1'b1);
        step();
        checkOutput("t6 row", oRowData, {pat(81), pat(80)});
        applyStimulus(1'b1, 16'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        step();
        step();
        checkBit("t6 done", oDone, 1'b1);
        checkBit("t6 framing sticky", oErrFraming, EXP_FRAMING);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axis_row_collector.md
# axis_row_collector

Receives the accelerator's 64-bit AXI-Stream result port and reassembles each pair of beats into one 128-bit PPU output row (16 × INT8). Rows are queued in a first-word-fall-through FIFO for the host-side writer. The block counts rows against a programmed total, signals completion, and flags beats that arrive while it is not ready. It sits between `axis_out_*` of the accelerator top and the result DMA/BRAM writer.

## Interface
- `FIFO_DEPTH_LOG2`, default 4: row FIFO depth is 2^N rows of 128 bits.
- `CNT_W`, default 16: width of the row counters.
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `s_axis_tdata`  in  64: result beat.
- `s_axis_tvalid`  in  1: beat valid.
- `s_axis_tready`  out  1: block can accept a beat.
- `s_axis_tlast`  in  1: end-of-frame marker; used only when the configuration macro is defined.
- `i_start`  in  1: level; a rising edge arms a frame.
- `i_row_count`  in  CNT_W: rows expected; sampled on the `i_start` rising edge.
- `o_row_data`  out  128: FIFO head, {high beat, low beat}.
- `o_row_valid`  out  1: FIFO non-empty.
- `i_row_ready`  in  1: consumer pops the head when `o_row_valid` is also high.
- `o_busy`  out  1: high in every state except IDLE.
- `o_done`  out  1: one-cycle completion pulse.
- `o_rows_received`  out  CNT_W: rows pushed in the current frame.
- `o_overrun`  out  1: sticky flag; a beat was dropped.
- `o_err_framing`  out  1: sticky framing error; held at 0 when the configuration macro is not defined.

## Operation
- States: IDLE, LOW, HIGH, DRAIN, DONE.
- IDLE:
  - On an `i_start` rising edge, latch `i_row_count`, clear the counter and both sticky flags.
  - If the count is non-zero, go to LOW; if it is 0, go to DONE.
- LOW:
  - `s_axis_tready` = 1.
  - On a handshake, latch `tdata` as the low half [63:0] and go to HIGH.
- HIGH:
  - `s_axis_tready` = !fifo_full. The full flag is registered; there is no pop lookahead.
  - On a handshake, push {tdata, low_half} and increment `o_rows_received`.
  - If the new count equals the target, go to DRAIN; otherwise go to LOW.
- DRAIN:
  - `s_axis_tready` = 0.
  - Wait for the FIFO to be empty, then go to DONE.
- DONE:
  - `o_done` = 1 for exactly one cycle, then go to IDLE.
- Overrun: when `s_axis_tvalid`=1 and `s_axis_tready`=0 in any state, the beat is dropped and `o_overrun` is set. The upstream gearbox does not honour tready, so this flag is the only loss indicator.
- An `i_start` rising edge while `o_busy` is high is ignored; the edge detector is still updated.
- FIFO:
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - No pop happens when empty.
  - No push happens when full, because tready is gated by the full flag.
- The counter is CNT_W bits and does not wrap within a frame; the maximum frame is 2^CNT_W−1 rows.
- Reset mid-frame discards any latched half-row and the FIFO contents; the block returns to IDLE.

## Timing
- Reset values:
  - `s_axis_tready`, `o_row_valid`, `o_busy`, `o_done`, `o_overrun` and `o_err_framing` are 0.
  - `o_row_data` and `o_rows_received` are 0.
- `s_axis_tready` is combinational from the state register and the registered full flag.
- A HIGH beat accepted at edge N gives `o_row_valid`=1 and the row on `o_row_data` after edge N. `o_rows_received` updates at the same edge.
- `i_start` rising edge sampled at edge N gives `s_axis_tready`=1 after edge N.
- With a zero row count, `o_done` is high in the cycle after edge N+1.
- When the last pop occurs at edge M, DRAIN sees the FIFO empty after M, and `o_done` is high after edge M+1.
- Sustained throughput is one beat per cycle, i.e. one row every 2 cycles, while the FIFO is not full.

## Configuration
- `ROW_COLLECTOR_TLAST_CHECK_EN` defined:
  - `s_axis_tlast`=1 on an accepted LOW beat sets `o_err_framing`; the beat is still treated as a low half.
  - `s_axis_tlast`=1 on a HIGH beat that is not the final row sets `o_err_framing`.
  - `s_axis_tlast`=0 on the final HIGH beat sets `o_err_framing`.
- Not defined: `s_axis_tlast` is ignored and `o_err_framing` is tied to 0.

## Test plan
- Start with `i_row_count`=2, `i_row_ready`=1, 4 back-to-back beats 0x11.., 0x22.., 0x33.., 0x44.. → row0 = {0x22..,0x11..}, row1 = {0x44..,0x33..}, `o_rows_received`=2, one `o_done` pulse, `o_overrun`=0.
- `i_row_count`=17, `i_row_ready`=0, continuous tvalid → 16 rows queued; tready drops in HIGH of row 17; the next beat sets `o_overrun`=1. Then raise `i_row_ready` → 16 rows pop in order and tready reasserts.
- `i_row_count`=0 and start → `s_axis_tready` stays 0; `o_done` is high for 1 cycle, 2 cycles after the start edge.
- After one LOW beat, pulse `rst_n` low → all outputs 0; a new start with count 1 → the first beat after restart lands in [63:0].
- Assert `i_start` again while in LOW → no counter or flag clear; the frame completes with the original count.
- With `ROW_COLLECTOR_TLAST_CHECK_EN`, count 1, tlast=1 on the first beat → `o_err_framing`=1. Without the macro, the same stimulus → `o_err_framing`=0.
